// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmitter: FSM states, frame-format encodings
// and data-length limits. UART_TX_BREAK_EN adds the BREAK state and its phases.
package uart_tx_pkg;

  localparam int unsigned DefDataLen = 8;
  localparam int unsigned MinDataLen = 5;
  localparam int unsigned MaxDataLen = 9;

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
  // Break sequence: one frame of low bits, low stop time, hold, then mark for T.
  typedef enum logic [1:0] {BrkBits, BrkStop, BrkHold, BrkMark} brk_phase_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`endif

  typedef enum logic [2:0] {
    ParNone  = 3'd0,
    ParOdd   = 3'd1,
    ParEven  = 3'd2,
    ParMark  = 3'd3,
    ParSpace = 3'd4
  } parity_e;

  typedef enum logic [1:0] {
    Stop1  = 2'd0,
    Stop15 = 2'd1,
    Stop2  = 2'd2
  } stop_e;

  // Out-of-range lengths fall back to 8 data bits.
  function automatic logic [3:0] eff_data_len(input logic [3:0] len, input int unsigned data_max);
    logic [3:0] res;
    res = 4'(DefDataLen);
    if (32'(len) >= MinDataLen && 32'(len) <= data_max) res = len;
    return res;
  endfunction

  function automatic parity_e decode_parity(input logic [2:0] mode);
    parity_e res;
    case (mode)
      3'd1:    res = ParOdd;
      3'd2:    res = ParEven;
      3'd3:    res = ParMark;
      3'd4:    res = ParSpace;
      default: res = ParNone;
    endcase
    return res;
  endfunction

  function automatic stop_e decode_stop(input logic [1:0] sel);
    stop_e res;
    case (sel)
      2'd0:    res = Stop1;
      2'd1:    res = Stop15;
      default: res = Stop2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Character write port of the UART transmitter (valid/ready).
interface uart_tx_engine_if #(
  parameter int unsigned DATA_MAX = 9
);
  logic [DATA_MAX-1:0] wr_data;
  logic                wr_valid;
  logic                wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered level; flush wins over push and pop.
module uart_tx_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned LevelW = AddrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full    = (level_q == LevelW'(Depth));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rptr_q];
  // Full blocks a write even if an entry leaves in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Pointer and level bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AddrW'(1);
      if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-fed, runtime frame format, back-to-back frames.
// Optional UART_TX_BREAK_EN adds break_i and a BREAK state.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int unsigned DIV_SIZE   = 16,
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [DIV_SIZE-1:0]           baud_div_i,
  input  logic [3:0]                    data_len_i,
  input  logic [2:0]                    parity_mode_i,
  input  logic [1:0]                    stop_bits_i,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_i,
`endif
  uart_tx_engine_if.slave               wr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          fifo_empty_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          tx_done_o
);
  // Wide enough to count a 2T stop period without wrapping.
  localparam int unsigned CntW = DIV_SIZE + 2;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [DATA_MAX-1:0] data_q;
  logic [3:0]          len_q;
  logic [DIV_SIZE-1:0] div_q;
  logic [CntW-1:0]     stop_last_q;
  logic                par_en_q, par_bit_q;
`ifdef UART_TX_BREAK_EN
  brk_phase_e          brk_ph_q, brk_ph_d;
  logic [3:0]          nbits_q;
`endif

  logic [DATA_MAX-1:0] fifo_rdata, masked;
  logic                fifo_full, fifo_empty;
  logic                pop, load, can_pop, launch, timing, phase_end;
  logic [CntW-1:0]     limit, t_full, stop_cycles, stop_last;
  logic [3:0]          len_eff;
  parity_e             par_mode;
  stop_e               stop_mode;
  logic                par_en, par_bit;
  logic [15:0]         data_ext;

  uart_tx_fifo #(
    .Width (DATA_MAX),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .push  (wr.wr_valid),
    .wdata (wr.wr_data),
    .pop   (pop),
    .flush (flush_i),
    .rdata (fifo_rdata),
    .level (fifo_level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr.wr_ready  = ~fifo_full;
  assign fifo_empty_o = fifo_empty;
  assign can_pop      = en_i & ~fifo_empty & ~flush_i;

  // Frame parameters derived from live config, captured only at load.
  always_comb begin
    len_eff   = eff_data_len(data_len_i, DATA_MAX);
    par_mode  = decode_parity(parity_mode_i);
    stop_mode = decode_stop(stop_bits_i);
    for (int i = 0; i < DATA_MAX; i++) begin
      masked[i] = fifo_rdata[i] & (i < int'(len_eff));
    end
    par_en  = (par_mode != ParNone);
    par_bit = 1'b0;
    unique case (par_mode)
      ParOdd:  par_bit = ~(^masked);
      ParEven: par_bit = ^masked;
      ParMark: par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
    t_full      = CntW'(baud_div_i) + CntW'(1);
    stop_cycles = t_full;
    unique case (stop_mode)
      Stop15:  stop_cycles = t_full + (t_full >> 1);
      Stop2:   stop_cycles = t_full << 1;
      default: stop_cycles = t_full;
    endcase
    stop_last = stop_cycles - CntW'(1);
  end

  // Bit timer end-of-phase detection.
  always_comb begin
    limit  = (state_q == StStop) ? stop_last_q : CntW'(div_q);
    timing = (state_q != StIdle);
`ifdef UART_TX_BREAK_EN
    if (state_q == StBreak && brk_ph_q == BrkStop) limit = stop_last_q;
    if (state_q == StBreak && brk_ph_q == BrkHold) timing = 1'b0;
`endif
    phase_end = timing & (cnt_q == limit);
  end

  // Next-state logic, pop decision and bit-timer next value.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    load      = 1'b0;
    launch    = (state_q == StIdle) | ((state_q == StStop) & phase_end);
`ifdef UART_TX_BREAK_EN
    brk_ph_d  = brk_ph_q;
`endif
    unique case (state_q)
      StStart: begin
        if (phase_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (phase_end) begin
          if (bit_idx_q == len_q - 4'd1) state_d = par_en_q ? StParity : StStop;
          else                           bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      StParity: begin
        if (phase_end) state_d = StStop;
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        unique case (brk_ph_q)
          BrkBits: begin
            if (phase_end) begin
              if (bit_idx_q == nbits_q - 4'd1) brk_ph_d = BrkStop;
              else                             bit_idx_d = bit_idx_q + 4'd1;
            end
          end
          BrkStop: if (phase_end) brk_ph_d = BrkHold;
          BrkHold: if (!break_i) brk_ph_d = BrkMark;
          default: if (phase_end) state_d = StIdle;
        endcase
      end
`endif
      default: ;
    endcase
    // Idle and the last stop cycle share one launch decision.
    if (launch) begin
      state_d = StIdle;
      if (can_pop) begin
        state_d = StStart;
        pop     = 1'b1;
        load    = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      if (break_i) begin
        state_d   = StBreak;
        pop       = 1'b0;
        load      = 1'b1;
        brk_ph_d  = BrkBits;
        bit_idx_d = '0;
      end
`endif
    end
    // Counter restarts on every phase boundary and never free-runs in idle.
    if (!timing || phase_end || state_d != state_q) cnt_d = '0;
    else                                             cnt_d = cnt_q + CntW'(1);
  end

  // FSM state and bit timer registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_BREAK_EN
      brk_ph_q  <= BrkBits;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
`ifdef UART_TX_BREAK_EN
      brk_ph_q  <= brk_ph_d;
`endif
    end
  end

  // Per-frame character and format snapshot.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q      <= '0;
      len_q       <= 4'(DefDataLen);
      div_q       <= '0;
      stop_last_q <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      nbits_q     <= '0;
`endif
    end else if (load) begin
      data_q      <= fifo_rdata;
      len_q       <= len_eff;
      div_q       <= baud_div_i;
      stop_last_q <= stop_last;
      par_en_q    <= par_en;
      par_bit_q   <= par_bit;
`ifdef UART_TX_BREAK_EN
      nbits_q     <= 4'd1 + len_eff + 4'(par_en);
`endif
    end
  end

  // Line level and status outputs decoded from the current state.
  always_comb begin
    data_ext  = 16'(data_q);
    tx_o      = 1'b1;
    busy_o    = (state_q != StIdle);
    tx_done_o = 1'b0;
    unique case (state_q)
      StStart:  tx_o = 1'b0;
      StData:   tx_o = data_ext[bit_idx_q];
      StParity: tx_o = par_bit_q;
      StStop: begin
        tx_o      = 1'b1;
        tx_done_o = phase_end;
      end
`ifdef UART_TX_BREAK_EN
      StBreak:  tx_o = (brk_ph_q == BrkMark);
`endif
      default:  tx_o = 1'b1;
    endcase
  end

endmodule
